// File: rtl/frame_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// frame_arbiter_pkg
// Shared definitions for the LED-matrix frame arbiter and its neighbours
// (pixel sources and the 0/1-code encoder):
//   - FSM state encoding of the arbiter
//   - source-ID encoding (SRC_A = menu/result screens, SRC_B = snake field)
//   - default frame geometry and inter-frame latch gap
//   - pick_source(): round-robin selection between the two requesters
// -----------------------------------------------------------------------------
package frame_arbiter_pkg;

    localparam int PIX_NUM_DEFAULT    = 64;     // 8x8 matrix
    localparam int GAP_CYCLES_DEFAULT = 15000;  // 300 us at 50 MHz
    localparam int RGB_W              = 24;     // GRB pixel word

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    // Caller guarantees at least one request is high. On a tie the source
    // that was not served last wins.
    function automatic src_t pick_source(input logic req_a,
                                         input logic req_b,
                                         input src_t last_grant);
        if (req_a && req_b) begin
            return (last_grant == SRC_A) ? SRC_B : SRC_A;
        end else if (req_a) begin
            return SRC_A;
        end else begin
            return SRC_B;
        end
    endfunction

endpackage

// File: rtl/frame_arbiter_gap_timer.sv
// -----------------------------------------------------------------------------
// frame_arbiter_gap_timer
// Counts the idle latch gap that follows every frame.
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   run        in   high while the arbiter sits in LATCH; low reloads the count
//   expire     out  high during the last (GAP_CYCLES-th) clock of the gap
// -----------------------------------------------------------------------------
module frame_arbiter_gap_timer
    import frame_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    logic [CNT_W-1:0] gap_cnt_q;
    logic [CNT_W-1:0] gap_cnt_d;

    assign expire = run && (gap_cnt_q == CNT_W'(GAP_CYCLES - 1));

    // Outside LATCH the counter sits at zero, so every gap starts from a
    // clean count without an explicit load pulse.
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (!run || expire) begin
            gap_cnt_d = '0;
        end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

// File: rtl/frame_arbiter.sv
// -----------------------------------------------------------------------------
// frame_arbiter
// Grants the shared 0/1-code encoder to one of two frame sources at a time,
// forwards that source's pixels, and enforces the latch gap between frames.
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   req_a, req_b            frame requests (level, held until frame done)
//   rgb_a, rgb_b            current GRB pixel of each source
//   tx_done                 encoder pulse: current pixel fully shifted out
//   gnt_a, gnt_b            grant levels (never both high)
//   pix_adv_a, pix_adv_b    pulse: granted source presents its next pixel
//   rgb_data                pixel forwarded to the encoder (0 when not sending)
//   frame_done              pulse on the tx_done of the last pixel
//   busy                    high whenever not IDLE
// -----------------------------------------------------------------------------
module frame_arbiter
    import frame_arbiter_pkg::*;
#(
    parameter int PIX_NUM    = PIX_NUM_DEFAULT,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [RGB_W-1:0] rgb_a,
    input  logic [RGB_W-1:0] rgb_b,
    input  logic             tx_done,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             pix_adv_a,
    output logic             pix_adv_b,
    output logic [RGB_W-1:0] rgb_data,
    output logic             frame_done,
    output logic             busy
);

    localparam int PIX_CNT_W = $clog2(PIX_NUM + 1);

    arb_state_t           state_q, state_d;
    // last_grant_q is updated only when a grant is issued, so during SEND it
    // also identifies the source that currently owns the encoder.
    src_t                 last_grant_q, last_grant_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;

    logic gap_expire;
    logic last_pix;
    src_t winner;

    assign winner   = pick_source(req_a, req_b, last_grant_q);
    assign last_pix = (pix_cnt_q == PIX_CNT_W'(PIX_NUM - 1));

    frame_arbiter_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .run       (state_q == ST_LATCH),
        .expire    (gap_expire)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pix_cnt_d    = pix_cnt_q;
        gnt_a        = 1'b0;
        gnt_b        = 1'b0;
        pix_adv_a    = 1'b0;
        pix_adv_b    = 1'b0;
        rgb_data     = '0;
        frame_done   = 1'b0;
        busy         = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    last_grant_d = winner;
                    state_d      = ST_SEND;
                end
            end

            ST_SEND: begin
                gnt_a    = (last_grant_q == SRC_A);
                gnt_b    = (last_grant_q == SRC_B);
                rgb_data = (last_grant_q == SRC_A) ? rgb_a : rgb_b;
                if (tx_done) begin
                    // The last pixel also gets an advance pulse so the
                    // source can rewind to pixel 0 for its next frame.
                    pix_adv_a = (last_grant_q == SRC_A);
                    pix_adv_b = (last_grant_q == SRC_B);
                    if (last_pix) begin
                        frame_done = 1'b1;
                        pix_cnt_d  = '0;
                        state_d    = ST_LATCH;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end

            ST_LATCH: begin
                if (gap_expire) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SRC_B;
            pix_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pix_cnt_q    <= pix_cnt_d;
        end
    end

endmodule

// File: tb/tb_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_arbiter
// Randomized frame traffic against a frame-level reference: the expected grant
// order is derived from request counts and round-robin fairness, the expected
// pixel stream from the values the driver presents. A monitor consumes both
// expectation queues as the DUT produces grants, pixel advances, frame ends
// and busy release.
// -----------------------------------------------------------------------------
module tb_frame_arbiter;

    localparam int PIX = 16;
    localparam int GAP = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        req_a, req_b;
    logic [23:0] rgb_a, rgb_b;
    logic        tx_done;
    logic        gnt_a, gnt_b;
    logic        pix_adv_a, pix_adv_b;
    logic [23:0] rgb_data;
    logic        frame_done;
    logic        busy;

    always #5 sys_clk = ~sys_clk;

    frame_arbiter #(
        .PIX_NUM    (PIX),
        .GAP_CYCLES (GAP)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req_a      (req_a),
        .req_b      (req_b),
        .rgb_a      (rgb_a),
        .rgb_b      (rgb_b),
        .tx_done    (tx_done),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .pix_adv_a  (pix_adv_a),
        .pix_adv_b  (pix_adv_b),
        .rgb_data   (rgb_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    typedef struct {
        int          src;   // 0 = A, 1 = B
        logic [23:0] rgb;
        bit          last;
    } adv_t;

    adv_t exp_adv[$];
    int   exp_gnt[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   model_last = 1;   // source served last; B after reset

    function automatic void check(input bit ok, input string name,
                                  input longint act, input longint req);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endfunction

    task automatic finish_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    endtask

    // ------------------------------------------------------------------ monitor
    initial begin
        bit   pa, pb;
        int   gap_ctr;
        int   got;
        int   want;
        adv_t e;
        pa = 0; pb = 0; gap_ctr = -1;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n !== 1'b1) begin
                pa = 0; pb = 0; gap_ctr = -1;
                continue;
            end
            if (gnt_a && gnt_b) check(0, "gnt_onehot", 3, 1);
            if ((gnt_a && !pa) || (gnt_b && !pb)) begin
                got = gnt_a ? 0 : 1;
                if (exp_gnt.size() == 0) begin
                    check(0, "gnt_unexpected", got, 15);
                end else begin
                    want = exp_gnt.pop_front();
                    check(got == want, "gnt_src", got, want);
                end
            end
            pa = gnt_a; pb = gnt_b;

            if (gap_ctr >= 0) begin
                gap_ctr++;
                if (!busy) begin
                    check(gap_ctr == GAP + 1, "busy_release", gap_ctr, GAP + 1);
                    gap_ctr = -1;
                end else if (gap_ctr > GAP + 1) begin
                    check(0, "busy_release", gap_ctr, GAP + 1);
                    gap_ctr = -1;
                end
            end

            if (pix_adv_a || pix_adv_b) begin
                if (exp_adv.size() == 0) begin
                    check(0, "adv_unexpected", {pix_adv_a, pix_adv_b}, 0);
                end else begin
                    e = exp_adv.pop_front();
                    check((pix_adv_a ^ pix_adv_b) && ((pix_adv_a ? 0 : 1) == e.src),
                          "pix_adv_src", {pix_adv_a, pix_adv_b}, (e.src == 0) ? 2 : 1);
                    check(rgb_data == e.rgb, "rgb_data", rgb_data, e.rgb);
                    check(frame_done == e.last, "frame_done", frame_done, e.last);
                    if (frame_done) begin
                        gap_ctr = 0;
                        $display("frame from source %s complete at %0t",
                                 (e.src == 0) ? "A" : "B", $time);
                    end
                end
            end else if (frame_done) begin
                check(0, "frame_done_unexpected", 1, 0);
            end
        end
    end

    // ------------------------------------------------------------------ driver
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_tx(input logic [23:0] ra, input logic [23:0] rb);
        rgb_a   = ra;
        rgb_b   = rb;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // tx_done while no frame is being sent must be ignored by the DUT; the
    // monitor flags any advance or frame_done it produces.
    task automatic stray_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            pulse_tx(24'($urandom), 24'($urandom));
        end
    endtask

    task automatic wait_grant();
        int k;
        for (k = 0; k < 200; k++) begin
            if (gnt_a || gnt_b) break;
            tick();
        end
        if (k >= 200) begin
            check(0, "grant_timeout", 0, 1);
            finish_run();
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 4 * GAP; k++) begin
            if (!busy) break;
            tick();
        end
        if (k >= 4 * GAP) begin
            check(0, "idle_timeout", busy, 0);
            finish_run();
        end
        tick();
    endtask

    task automatic send_pixels(input int src, input int count, input int drop_at,
                               input int raise_b_at);
        for (int i = 0; i < count; i++) begin
            adv_t        e;
            logic [23:0] ra, rb;
            repeat ($urandom_range(0, 3)) begin
                rgb_a = 24'($urandom);
                rgb_b = 24'($urandom);
                tick();
            end
            ra     = 24'($urandom);
            rb     = 24'($urandom);
            e.src  = src;
            e.rgb  = (src == 0) ? ra : rb;
            e.last = (i == PIX - 1);
            exp_adv.push_back(e);
            if (i == drop_at)    req_a = 1'b0;
            if (i == raise_b_at) req_b = 1'b1;
            pulse_tx(ra, rb);
        end
    endtask

    // na/nb frames wanted from A/B; late_b raises B's request during the
    // first (A) frame; drop_mid releases req_a partway through A's last frame.
    task automatic run_scenario(input int na, input int nb, input bit late_b,
                                input bit drop_mid);
        int order[$];
        int ra, rb, s, rem_a, rem_b, drop_at, raise_at;
        bit b_avail;
        ra = na; rb = nb;
        b_avail = (nb > 0) && !late_b;
        while (ra + rb > 0) begin
            if (ra > 0 && rb > 0 && b_avail) s = (model_last == 0) ? 1 : 0;
            else if (ra > 0)                 s = 0;
            else                             s = 1;
            order.push_back(s);
            exp_gnt.push_back(s);
            model_last = s;
            if (s == 0) ra--; else rb--;
            b_avail = (nb > 0);
        end
        $display("scenario: na=%0d nb=%0d late_b=%0d drop_mid=%0d", na, nb, late_b, drop_mid);

        stray_pulses(2);
        req_a = (na > 0);
        req_b = (nb > 0) && !late_b;
        rem_a = na; rem_b = nb;
        foreach (order[f]) begin
            wait_grant();
            drop_at  = -1;
            raise_at = -1;
            if (order[f] == 0 && rem_a == 1 && drop_mid) drop_at = $urandom_range(1, PIX - 2);
            if (f == 0 && late_b) raise_at = 3;
            send_pixels(order[f], PIX, drop_at, raise_at);
            if (order[f] == 0) begin
                rem_a--;
                if (rem_a == 0) req_a = 1'b0;
            end else begin
                rem_b--;
                if (rem_b == 0) req_b = 1'b0;
            end
            stray_pulses($urandom_range(0, 2));
        end
        wait_idle();
    endtask

    task automatic check_outputs_low(input string tag);
        check(gnt_a == 0,      {tag, "_gnt_a"},      gnt_a, 0);
        check(gnt_b == 0,      {tag, "_gnt_b"},      gnt_b, 0);
        check(pix_adv_a == 0,  {tag, "_pix_adv_a"},  pix_adv_a, 0);
        check(pix_adv_b == 0,  {tag, "_pix_adv_b"},  pix_adv_b, 0);
        check(frame_done == 0, {tag, "_frame_done"}, frame_done, 0);
        check(busy == 0,       {tag, "_busy"},       busy, 0);
        check(rgb_data == 0,   {tag, "_rgb_data"},   rgb_data, 0);
    endtask

    task automatic reset_mid_frame();
        $display("scenario: reset during A frame");
        req_a = 1'b1;
        req_b = 1'b0;
        exp_gnt.push_back(0);
        model_last = 0;
        wait_grant();
        send_pixels(0, PIX / 2, -1, -1);
        tick();
        #2;
        req_b     = 1'b1;
        tx_done   = 1'b1;
        rgb_a     = 24'hFFFFFF;
        rgb_b     = 24'hFFFFFF;
        sys_rst_n = 1'b0;
        #1;
        check_outputs_low("reset_mid");
        exp_adv.delete();
        exp_gnt.delete();
        model_last = 1;
        tick();
        tx_done = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick();
        // Full frames from both: A must win the tie and needs all PIX pixels.
        run_scenario(1, 1, 0, 0);
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        sys_rst_n = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        rgb_a     = 24'h0;
        rgb_b     = 24'h0;
        tx_done   = 1'b0;
        tick();
        tx_done = 1'b1;
        rgb_a   = 24'h123456;
        #1;
        check_outputs_low("reset");
        tick();
        tx_done   = 1'b0;
        sys_rst_n = 1'b1;
        tick();

        run_scenario(2, 2, 0, 0);   // tie from reset: A, B, A, B
        run_scenario(1, 0, 0, 0);
        run_scenario(2, 0, 0, 0);   // back-to-back frames of one source
        run_scenario(1, 1, 1, 0);   // B arrives during A's frame
        run_scenario(1, 0, 0, 1);   // A releases its request mid-frame
        reset_mid_frame();

        for (int r = 0; r < 12; r++) begin
            int na, nb;
            bit lb, dm;
            na = $urandom_range(0, 2);
            nb = $urandom_range(0, 2);
            if (na + nb == 0) na = 1;
            lb = (na > 0) && (nb > 0) && ($urandom_range(0, 2) == 0);
            dm = (na > 0) && ($urandom_range(0, 2) == 0);
            run_scenario(na, nb, lb, dm);
        end

        repeat (5) tick();
        check(exp_adv.size() == 0, "pending_pixels", exp_adv.size(), 0);
        check(exp_gnt.size() == 0, "pending_grants", exp_gnt.size(), 0);
        finish_run();
    end

    initial begin
        #5_000_000;
        check(0, "global_timeout", 0, 1);
        finish_run();
    end

endmodule
